// File: rtl/game_pkg.sv
// Shared definitions for the game control sequencer: one-hot state layout and on/off levels.
package game_pkg;

    localparam int unsigned NUM_STATES = 7;

    // Bit positions of each phase in the one-hot state register.
    localparam int unsigned INIT         = 0;
    localparam int unsigned IDLE         = 1;
    localparam int unsigned ERASE        = 2;
    localparam int unsigned GEN_MOVE     = 3;
    localparam int unsigned APPLY_MOVE   = 4;
    localparam int unsigned DRAW_LINK    = 5;
    localparam int unsigned DRAW_ENEMIES = 6;

    localparam logic ON  = 1'b1;
    localparam logic OFF = 1'b0;

    typedef enum logic [NUM_STATES-1:0] {
        StInit        = 7'b000_0001,
        StIdle        = 7'b000_0010,
        StErase       = 7'b000_0100,
        StGenMove     = 7'b000_1000,
        StApplyMove   = 7'b001_0000,
        StDrawLink    = 7'b010_0000,
        StDrawEnemies = 7'b100_0000
    } state_t;

    // States whose dwell time is tracked: INIT for its fixed hold, the rest for the watchdog.
    function automatic logic dwell_counts(state_t s);
        return s[INIT] | s[ERASE] | s[DRAW_LINK] | s[DRAW_ENEMIES];
    endfunction

endpackage

// File: rtl/game_control_fsm_frame_timer.sv
// Free-running frame timer: one-cycle tick every FRAME_CYCLES clocks.
module frame_timer #(
    parameter int unsigned FRAME_CYCLES = 833333
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);

    localparam int unsigned CNT_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_CYCLES - 1);

    logic [CNT_W-1:0] count_q;

    assign tick = (count_q == LAST);

    // Count 0..FRAME_CYCLES-1, wrapping on the tick cycle.
    always_ff @(posedge clock) begin
        if (reset || tick) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/game_control_fsm.sv
// Per-frame phase sequencer: init, idle, erase, gen/apply move, draw link, draw enemies.
module game_control_fsm
    import game_pkg::*;
#(
    parameter int unsigned FRAME_CYCLES   = 833333,
    parameter int unsigned INIT_CYCLES    = 4,
    parameter int unsigned TIMEOUT_CYCLES = 262143
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pause,
    input  logic       erase_done,
    input  logic       link_draw_done,
    input  logic       enemies_draw_done,
    output logic       init,
    output logic       idle,
    output logic       erase,
    output logic       gen_move,
    output logic       apply_move,
    output logic       draw_link,
    output logic       draw_enemies,
    output logic [7:0] frame_count,
    output logic       overrun,
    output logic       timeout
);

    localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > INIT_CYCLES) ? TIMEOUT_CYCLES : INIT_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t INIT_LAST = cnt_t'(INIT_CYCLES - 1);
    localparam cnt_t WDOG_LAST = cnt_t'(TIMEOUT_CYCLES - 1);

    state_t     state_q, state_d;
    cnt_t       dwell_q, dwell_d;
    logic       tick_pending_q, tick_pending_d;
    logic [7:0] frame_count_q, frame_count_d;
    logic       overrun_q, overrun_d;
    logic       timeout_q, timeout_d;
    logic       tick;
    logic       wdog_expired;

    frame_timer #(
        .FRAME_CYCLES(FRAME_CYCLES)
    ) u_frame_timer (
        .clock(clock),
        .reset(reset),
        .tick (tick)
    );

    // Phase outputs come straight from the one-hot register bits.
    assign init         = state_q[INIT];
    assign idle         = state_q[IDLE];
    assign erase        = state_q[ERASE];
    assign gen_move     = state_q[GEN_MOVE];
    assign apply_move   = state_q[APPLY_MOVE];
    assign draw_link    = state_q[DRAW_LINK];
    assign draw_enemies = state_q[DRAW_ENEMIES];
    assign frame_count  = frame_count_q;
    assign overrun      = overrun_q;
    assign timeout      = timeout_q;

    // Next-state, tick bookkeeping, watchdog and frame counting.
    always_comb begin
        state_d        = state_q;
        dwell_d        = '0;
        tick_pending_d = tick_pending_q;
        frame_count_d  = frame_count_q;
        overrun_d      = overrun_q;
        timeout_d      = timeout_q;
        wdog_expired   = (dwell_q == WDOG_LAST);

        // A second tick before the first is consumed is dropped and flagged.
        if (tick && !state_q[INIT]) begin
            if (tick_pending_q) begin
                overrun_d = ON;
            end else begin
                tick_pending_d = ON;
            end
        end

        unique case (state_q)
            StInit: begin
                tick_pending_d = OFF;
                if (dwell_q == INIT_LAST) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                // A tick in this very cycle counts as pending so the frame starts at once.
                if ((tick_pending_q || tick) && !pause) begin
                    state_d        = StErase;
                    tick_pending_d = OFF;
                end
            end
            StErase: begin
                if (erase_done || wdog_expired) begin
                    state_d = StGenMove;
                    if (!erase_done) begin
                        timeout_d = ON;
                    end
                end
            end
            StGenMove: begin
                state_d = StApplyMove;
            end
            StApplyMove: begin
                state_d = StDrawLink;
            end
            StDrawLink: begin
                if (link_draw_done || wdog_expired) begin
                    state_d = StDrawEnemies;
                    if (!link_draw_done) begin
                        timeout_d = ON;
                    end
                end
            end
            StDrawEnemies: begin
                if (enemies_draw_done || wdog_expired) begin
                    state_d       = StIdle;
                    frame_count_d = frame_count_q + 8'd1;
                    if (!enemies_draw_done) begin
                        timeout_d = ON;
                    end
                end
            end
            default: begin
                state_d = StInit;
            end
        endcase

        // Dwell counter restarts on every state change.
        if ((state_d == state_q) && dwell_counts(state_q)) begin
            dwell_d = dwell_q + cnt_t'(1);
        end
    end

    // State and status registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= StInit;
            dwell_q        <= '0;
            tick_pending_q <= OFF;
            frame_count_q  <= '0;
            overrun_q      <= OFF;
            timeout_q      <= OFF;
        end else begin
            state_q        <= state_d;
            dwell_q        <= dwell_d;
            tick_pending_q <= tick_pending_d;
            frame_count_q  <= frame_count_d;
            overrun_q      <= overrun_d;
            timeout_q      <= timeout_d;
        end
    end

endmodule

// File: tb/tb_game_control_fsm.sv
// Scoreboard bench for game_control_fsm: expected phase/status snapshots queued per cycle.
module tb_game_control_fsm;

    localparam int unsigned FRAME_CYCLES   = 20;
    localparam int unsigned INIT_CYCLES    = 4;
    localparam int unsigned TIMEOUT_CYCLES = 50;
    localparam int          LIMIT          = 120;

    // Phase vector order: {draw_enemies, draw_link, apply_move, gen_move, erase, idle, init}.
    localparam logic [6:0] P_INIT  = 7'b000_0001;
    localparam logic [6:0] P_IDLE  = 7'b000_0010;
    localparam logic [6:0] P_ERASE = 7'b000_0100;
    localparam logic [6:0] P_GEN   = 7'b000_1000;
    localparam logic [6:0] P_APPLY = 7'b001_0000;
    localparam logic [6:0] P_LINK  = 7'b010_0000;
    localparam logic [6:0] P_ENEM  = 7'b100_0000;

    typedef struct {
        int          cyc;
        logic [16:0] val;
        string       name;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       pause = 1'b0;
    logic       erase_done = 1'b0;
    logic       link_draw_done = 1'b0;
    logic       enemies_draw_done = 1'b0;
    logic       init, idle, erase, gen_move, apply_move, draw_link, draw_enemies;
    logic [7:0] frame_count;
    logic       overrun, timeout;

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    exp_t sb[$];

    game_control_fsm #(
        .FRAME_CYCLES  (FRAME_CYCLES),
        .INIT_CYCLES   (INIT_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .pause            (pause),
        .erase_done       (erase_done),
        .link_draw_done   (link_draw_done),
        .enemies_draw_done(enemies_draw_done),
        .init             (init),
        .idle             (idle),
        .erase            (erase),
        .gen_move         (gen_move),
        .apply_move       (apply_move),
        .draw_link        (draw_link),
        .draw_enemies     (draw_enemies),
        .frame_count      (frame_count),
        .overrun          (overrun),
        .timeout          (timeout)
    );

    always #5 clock = ~clock;

    function automatic logic [16:0] observed();
        return {draw_enemies, draw_link, apply_move, gen_move, erase, idle, init,
                frame_count, overrun, timeout};
    endfunction

    task automatic expect_at(input int c, input logic [6:0] p, input logic [7:0] fc,
                             input logic ov, input logic to, input string nm);
        exp_t e;
        e.cyc  = c;
        e.val  = {p, fc, ov, to};
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic next_cycle();
        @(negedge clock);
        cyc++;
    endtask

    // Reset is applied across one rising edge; cycle 0 is the first cycle after release.
    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        cyc   = 0;
    endtask

    task automatic test_reset();
        exp_t e;
        pause = 1'b0; erase_done = 1'b0; link_draw_done = 1'b0; enemies_draw_done = 1'b0;
        do_reset();
        n_cmp++;
        if (observed() !== {P_INIT, 8'd0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_values: got %b, expected %b", observed(), {P_INIT, 10'd0});
        end
        expect_at(1, P_INIT, 0, 0, 0, "init_c1");
        expect_at(3, P_INIT, 0, 0, 0, "init_c3");
        expect_at(4, P_IDLE, 0, 0, 0, "idle_c4");
        expect_at(19, P_IDLE, 0, 0, 0, "idle_before_tick");
        expect_at(20, P_ERASE, 0, 0, 0, "erase_after_tick");
        expect_at(21, P_ERASE, 0, 0, 0, "erase_held");
        while (sb.size() != 0 && cyc <= LIMIT) begin
            while (sb.size() != 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                n_cmp++;
                if (observed() !== e.val) begin
                    n_err++;
                    $display("FAIL %s cyc %0d: got %b, expected %b", e.name, cyc, observed(), e.val);
                end
            end
            next_cycle();
        end
        if (sb.size() != 0) begin
            n_cmp++; n_err++;
            $display("FAIL reset_budget: %0d checks unreached, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_all_done();
        exp_t e;
        pause = 1'b0; erase_done = 1'b1; link_draw_done = 1'b1; enemies_draw_done = 1'b1;
        do_reset();
        expect_at(20, P_ERASE, 0, 0, 0, "f1_erase");
        expect_at(21, P_GEN, 0, 0, 0, "f1_gen");
        expect_at(22, P_APPLY, 0, 0, 0, "f1_apply");
        expect_at(23, P_LINK, 0, 0, 0, "f1_link");
        expect_at(24, P_ENEM, 0, 0, 0, "f1_enemies");
        expect_at(25, P_IDLE, 1, 0, 0, "f1_done");
        expect_at(39, P_IDLE, 1, 0, 0, "f2_wait");
        expect_at(40, P_ERASE, 1, 0, 0, "f2_erase");
        expect_at(44, P_ENEM, 1, 0, 0, "f2_enemies");
        expect_at(45, P_IDLE, 2, 0, 0, "f2_done");
        expect_at(60, P_ERASE, 2, 0, 0, "f3_erase");
        expect_at(65, P_IDLE, 3, 0, 0, "f3_done");
        while (sb.size() != 0 && cyc <= LIMIT) begin
            while (sb.size() != 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                n_cmp++;
                if (observed() !== e.val) begin
                    n_err++;
                    $display("FAIL %s cyc %0d: got %b, expected %b", e.name, cyc, observed(), e.val);
                end
            end
            next_cycle();
        end
        if (sb.size() != 0) begin
            n_cmp++; n_err++;
            $display("FAIL all_done_budget: %0d checks unreached, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_overrun();
        exp_t e;
        pause = 1'b0; erase_done = 1'b1; link_draw_done = 1'b1; enemies_draw_done = 1'b0;
        do_reset();
        expect_at(24, P_ENEM, 0, 0, 0, "ovr_enter_enemies");
        expect_at(40, P_ENEM, 0, 0, 0, "ovr_one_tick");
        expect_at(59, P_ENEM, 0, 0, 0, "ovr_before_second");
        expect_at(60, P_ENEM, 0, 1, 0, "ovr_set");
        expect_at(61, P_IDLE, 1, 1, 0, "ovr_frame_once");
        expect_at(62, P_ERASE, 1, 1, 0, "ovr_pending_kept");
        expect_at(66, P_ENEM, 1, 1, 0, "ovr_f2_enemies");
        expect_at(67, P_IDLE, 2, 1, 0, "ovr_f2_done");
        while (sb.size() != 0 && cyc <= LIMIT) begin
            enemies_draw_done = (cyc >= 60);
            while (sb.size() != 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                n_cmp++;
                if (observed() !== e.val) begin
                    n_err++;
                    $display("FAIL %s cyc %0d: got %b, expected %b", e.name, cyc, observed(), e.val);
                end
            end
            next_cycle();
        end
        if (sb.size() != 0) begin
            n_cmp++; n_err++;
            $display("FAIL overrun_budget: %0d checks unreached, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_pause();
        exp_t e;
        pause = 1'b0; erase_done = 1'b1; link_draw_done = 1'b1; enemies_draw_done = 1'b1;
        do_reset();
        expect_at(19, P_IDLE, 0, 0, 0, "pause_tick");
        expect_at(20, P_IDLE, 0, 0, 0, "pause_hold");
        expect_at(26, P_IDLE, 0, 0, 0, "pause_release");
        expect_at(27, P_ERASE, 0, 0, 0, "pause_erase");
        expect_at(28, P_GEN, 0, 0, 0, "pause_gen");
        expect_at(32, P_IDLE, 1, 0, 0, "pause_f1_done");
        expect_at(33, P_IDLE, 1, 0, 0, "pause_pending_clear");
        expect_at(39, P_IDLE, 1, 0, 0, "pause_next_tick");
        expect_at(40, P_ERASE, 1, 0, 0, "pause_f2_erase");
        expect_at(45, P_IDLE, 2, 0, 0, "pause_f2_done");
        while (sb.size() != 0 && cyc <= LIMIT) begin
            pause = (cyc >= 10 && cyc < 26);
            while (sb.size() != 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                n_cmp++;
                if (observed() !== e.val) begin
                    n_err++;
                    $display("FAIL %s cyc %0d: got %b, expected %b", e.name, cyc, observed(), e.val);
                end
            end
            next_cycle();
        end
        pause = 1'b0;
        if (sb.size() != 0) begin
            n_cmp++; n_err++;
            $display("FAIL pause_budget: %0d checks unreached, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_watchdog();
        exp_t e;
        int   link_cycles;
        link_cycles = 0;
        pause = 1'b0; erase_done = 1'b1; link_draw_done = 1'b0; enemies_draw_done = 1'b1;
        do_reset();
        expect_at(22, P_APPLY, 0, 0, 0, "wd_apply");
        expect_at(23, P_LINK, 0, 0, 0, "wd_link_enter");
        expect_at(59, P_LINK, 0, 0, 0, "wd_link_mid");
        expect_at(60, P_LINK, 0, 1, 0, "wd_overrun");
        expect_at(72, P_LINK, 0, 1, 0, "wd_link_last");
        expect_at(73, P_ENEM, 0, 1, 1, "wd_fired");
        expect_at(74, P_IDLE, 1, 1, 1, "wd_frame_done");
        expect_at(75, P_ERASE, 1, 1, 1, "wd_next_frame");
        expect_at(78, P_LINK, 1, 1, 1, "wd_link_again");
        expect_at(80, P_LINK, 1, 1, 1, "wd_link_hold");
        while (sb.size() != 0 && cyc <= LIMIT) begin
            if (cyc < 75 && draw_link) link_cycles++;
            while (sb.size() != 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                n_cmp++;
                if (observed() !== e.val) begin
                    n_err++;
                    $display("FAIL %s cyc %0d: got %b, expected %b", e.name, cyc, observed(), e.val);
                end
            end
            next_cycle();
        end
        if (sb.size() != 0) begin
            n_cmp++; n_err++;
            $display("FAIL watchdog_budget: %0d checks unreached, expected 0", sb.size());
            sb.delete();
        end
        n_cmp++;
        if (link_cycles !== 50) begin
            n_err++;
            $display("FAIL wd_link_length: got %0d cycles, expected 50", link_cycles);
        end
    endtask

    // Continues from test_watchdog, which leaves the DUT stuck in DRAW_LINK with flags set.
    task automatic test_reset_mid_frame();
        exp_t e;
        n_cmp++;
        if ({draw_link, overrun, timeout} !== 3'b111) begin
            n_err++;
            $display("FAIL mid_precondition: got link/ovr/to %b, expected 111",
                     {draw_link, overrun, timeout});
        end
        reset = 1'b1;
        @(negedge clock);
        n_cmp++;
        if (observed() !== {P_INIT, 8'd0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL mid_reset: got %b, expected %b", observed(), {P_INIT, 10'd0});
        end
        reset = 1'b0;
        cyc   = 0;
        expect_at(3, P_INIT, 0, 0, 0, "mid_init_hold");
        expect_at(4, P_IDLE, 0, 0, 0, "mid_idle");
        expect_at(20, P_ERASE, 0, 0, 0, "mid_erase");
        while (sb.size() != 0 && cyc <= LIMIT) begin
            while (sb.size() != 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                n_cmp++;
                if (observed() !== e.val) begin
                    n_err++;
                    $display("FAIL %s cyc %0d: got %b, expected %b", e.name, cyc, observed(), e.val);
                end
            end
            next_cycle();
        end
        if (sb.size() != 0) begin
            n_cmp++; n_err++;
            $display("FAIL mid_budget: %0d checks unreached, expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        test_reset();
        test_all_done();
        test_overrun();
        test_pause();
        test_watchdog();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
